axis_header_edit: RTL

Per-packet AXI-Stream header editor, parametrised in data width. A command handshake selects the mode for each packet:
- insert: prepend 1..DATA_BYTE_WD header bytes.
- strip: remove 0..DATA_BYTE_WD leading payload bytes.

Output bytes are repacked so every non-last beat is full. The block sits between packet source and sink in the stream datapath. It generalises the single-mode header inserter with strip mode, full-beat headers, explicit tail-flush and empty-packet drop.

---
 rtl/axis_pkg.sv | 34 +++
 rtl/axis_byte_aligner.sv | 43 ++++
 rtl/axis_header_edit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// Shared types and byte-lane helpers for the AXI-Stream header editor.
// Helper functions operate on a fixed maximum lane count; callers size-cast the results.
package axis_pkg;

  localparam int MAX_BYTES = 128;
  localparam int PCW       = 8;

  typedef logic [PCW-1:0]       cnt_t;
  typedef logic [MAX_BYTES-1:0] mask_t;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM,
    FLUSH
  } state_e;

  function automatic cnt_t popcount_keep(input mask_t keep);
    cnt_t c;
    c = '0;
    for (int i = 0; i < MAX_BYTES; i++) c = c + cnt_t'(keep[i]);
    return c;
  endfunction

  // n ones packed against the top of an nbytes-wide lane mask
  function automatic mask_t left_mask(input cnt_t n, input cnt_t nbytes);
    mask_t m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++)
      if (i < int'(nbytes) && i >= int'(nbytes) - int'(n)) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/axis_byte_aligner.sv
// Concatenate-and-select of the residual bytes with the incoming beat.
// Produces the full/last output beat, the left-aligned tail and their lane masks.
module axis_byte_aligner
  import axis_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int CNT_WD       = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic [DATA_WD-1:0]      r_i,
  input  logic [CNT_WD-1:0]       o_i,
  input  logic [DATA_WD-1:0]      data_i,
  input  logic [DATA_BYTE_WD-1:0] keep_i,
  output logic [DATA_WD-1:0]      head_data_o,
  output logic [DATA_BYTE_WD-1:0] head_keep_o,
  output logic [DATA_WD-1:0]      tail_data_o,
  output logic [DATA_BYTE_WD-1:0] tail_keep_o,
  output cnt_t                    total_o
);

  localparam cnt_t NB = cnt_t'(DATA_BYTE_WD);

  logic [CNT_WD+2:0]    shamt;
  logic [DATA_WD-1:0]   head_raw;
  logic [DATA_WD-1:0]   tail_raw;

  always_comb begin
    shamt       = {o_i, 3'b000};
    // Residual bytes sit in the low o lanes of R and precede data_i on the wire
    head_raw    = DATA_WD'({r_i, data_i} >> shamt);
    tail_raw    = DATA_WD'({data_i, {DATA_WD{1'b0}}} >> shamt);
    total_o     = cnt_t'(o_i) + popcount_keep(mask_t'(keep_i));
    head_keep_o = DATA_BYTE_WD'(left_mask((total_o > NB) ? NB : total_o, NB));
    tail_keep_o = DATA_BYTE_WD'(left_mask((total_o > NB) ? (total_o - NB) : cnt_t'(0), NB));
    head_data_o = '0;
    tail_data_o = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      head_data_o[8*i +: 8] = head_raw[8*i +: 8] & {8{head_keep_o[i]}};
      tail_data_o[8*i +: 8] = tail_raw[8*i +: 8] & {8{tail_keep_o[i]}};
    end
  end

endmodule

// File: rtl/axis_header_edit.sv
// Per-packet AXI-Stream header editor: prepends a header or strips leading bytes,
// repacking the stream so every non-last output beat is full.
module axis_header_edit
  import axis_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int CNT_WD       = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic [CNT_WD-1:0]       byte_insert_cnt,
  input  logic                    mode_strip,
  output logic                    ready_insert,
  output logic                    pkt_drop
);

  localparam cnt_t              NB  = cnt_t'(DATA_BYTE_WD);
  localparam logic [CNT_WD-1:0] N_C = CNT_WD'(DATA_BYTE_WD);

  state_e                  state_q, state_d;
  logic [DATA_WD-1:0]      r_q, r_d;
  logic [CNT_WD-1:0]       o_q, o_d;
  logic                    valid_q, valid_d;
  logic [DATA_WD-1:0]      data_q, data_d;
  logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
  logic                    last_q, last_d;
  logic                    drop_q, drop_d;

  logic                    load_en, beat_fire, cmd_fire;
  logic [CNT_WD-1:0]       ins_cnt, strip_cnt;
  logic [DATA_WD-1:0]      head_data, tail_data;
  logic [DATA_BYTE_WD-1:0] head_keep, tail_keep;
  cnt_t                    total;
  logic                    unused_keep_insert;

  assign unused_keep_insert = ^keep_insert;

  assign load_en      = !valid_q || ready_out;
  assign ready_in     = ((state_q == PRIME) || (state_q == STREAM)) && load_en;
  assign ready_insert = (state_q == IDLE);
  assign beat_fire    = valid_in && ready_in;
  assign cmd_fire     = valid_insert && ready_insert;

  // Out-of-range counts clamp to a full beat
  assign ins_cnt   = (byte_insert_cnt == '0 || byte_insert_cnt > N_C) ? N_C : byte_insert_cnt;
  assign strip_cnt = (byte_insert_cnt > N_C) ? N_C : byte_insert_cnt;

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign keep_out  = keep_q;
  assign last_out  = last_q;
  assign pkt_drop  = drop_q;

  axis_byte_aligner #(
    .DATA_WD     (DATA_WD),
    .DATA_BYTE_WD(DATA_BYTE_WD),
    .CNT_WD      (CNT_WD)
  ) u_aligner (
    .r_i        (r_q),
    .o_i        (o_q),
    .data_i     (data_in),
    .keep_i     (keep_in),
    .head_data_o(head_data),
    .head_keep_o(head_keep),
    .tail_data_o(tail_data),
    .tail_keep_o(tail_keep),
    .total_o    (total)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      o_q     <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      o_q     <= o_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    o_d     = o_q;
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    drop_d  = 1'b0;
    if (load_en) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (!mode_strip) begin
            r_d     = data_insert;
            o_d     = ins_cnt;
            state_d = STREAM;
          end else if (strip_cnt == '0) begin
            o_d     = '0;
            state_d = STREAM;
          end else begin
            o_d     = N_C - strip_cnt;
            state_d = PRIME;
          end
        end
      end
      PRIME: begin
        if (beat_fire) begin
          r_d = data_in;
          if (!last_in) begin
            state_d = STREAM;
          end else begin
            // Single-beat strip packet: whatever survives the strip is the whole output
            state_d = IDLE;
            if (total > NB) begin
              valid_d = 1'b1;
              data_d  = tail_data;
              keep_d  = tail_keep;
              last_d  = 1'b1;
            end else begin
              drop_d = 1'b1;
            end
          end
        end
      end
      STREAM: begin
        if (beat_fire) begin
          valid_d = 1'b1;
          data_d  = head_data;
          keep_d  = head_keep;
          if (!last_in) begin
            last_d = 1'b0;
            r_d    = data_in;
          end else if (total <= NB) begin
            last_d  = 1'b1;
            state_d = IDLE;
          end else begin
            last_d  = 1'b0;
            r_d     = tail_data;
            o_d     = CNT_WD'(total - NB);
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (load_en) begin
          valid_d = 1'b1;
          data_d  = r_q;
          keep_d  = DATA_BYTE_WD'(left_mask(cnt_t'(o_q), NB));
          last_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
